// File: rtl/rocc_arb_pkg.sv
// Shared types and constants for the RoCC accelerator arbiter.
// The optional ROCC_ARB_PERF_EN build adds performance counters to the top level.
package rocc_arb_pkg;

    localparam int ROCC_XLEN = 64;

    localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
    localparam logic [6:0] OPC_CUSTOM2 = 7'h5B;
    localparam logic [6:0] OPC_CUSTOM3 = 7'h7B;

    // funct value that acknowledges a pending bad-command interrupt
    localparam logic [6:0] FUNCT_CLEAR_BAD = 7'h7F;

    typedef struct packed {
        logic [6:0]           funct;
        logic [4:0]           rs2;
        logic [4:0]           rs1;
        logic                 xd;
        logic                 xs1;
        logic                 xs2;
        logic [4:0]           rd;
        logic [6:0]           opcode;
        logic [ROCC_XLEN-1:0] rs1_data;
        logic [ROCC_XLEN-1:0] rs2_data;
    } rocc_cmd_t;

    // custom0..custom3 differ only in opcode bits [6:5]
    function automatic logic [1:0] cmd_target(input logic [6:0] opcode);
        return opcode[6:5];
    endfunction

endpackage

// File: rtl/rocc_accel_arbiter_rr.sv
// Round-robin selector with grant lock, used to pick which response goes to the core.
// Part of rocc_accel_arbiter (optional macro ROCC_ARB_PERF_EN does not affect this file).
module rocc_rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          ready,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] search_idx_s;
    logic [IW-1:0] cand_idx_s;
    logic          search_hit_s;

    // Find the first requester at or after the pointer, wrapping around
    always_comb begin
        search_idx_s = {IW{1'b0}};
        search_hit_s = 1'b0;
        cand_idx_s   = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_idx_s   = (int'(ptr_q) + k >= N) ? IW'(int'(ptr_q) + k - N) : IW'(int'(ptr_q) + k);
            search_idx_s = (!search_hit_s && req[cand_idx_s]) ? cand_idx_s : search_idx_s;
            search_hit_s = search_hit_s | req[cand_idx_s];
        end
    end

    // A stalled grant stays put so the presented response cannot change under the core
    always_comb begin
        if (lock_q) begin
            gnt_idx   = lock_idx_q;
            gnt_valid = req[lock_idx_q];
        end else begin
            gnt_idx   = search_idx_s;
            gnt_valid = search_hit_s;
        end
    end

    // Next pointer and lock state
    always_comb begin
        lock_d     = gnt_valid && !ready;
        lock_idx_d = gnt_idx;
        if (gnt_valid && ready) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? {IW{1'b0}} : gnt_idx + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q      <= {IW{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {IW{1'b0}};
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/rocc_accel_arbiter.sv
// RoCC command router / response arbiter between one core and up to four accelerators.
// Define ROCC_ARB_PERF_EN to add perf_issued / perf_stall counter outputs.
module rocc_accel_arbiter
    import rocc_arb_pkg::*;
#(
    parameter int NUM_ACCEL = 4,
    parameter int XLEN      = ROCC_XLEN
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      core_cmd_valid,
    output logic                      core_cmd_ready,
    input  rocc_cmd_t                 core_cmd_bits,
    output logic [NUM_ACCEL-1:0]      acc_cmd_valid,
    input  logic [NUM_ACCEL-1:0]      acc_cmd_ready,
    output rocc_cmd_t                 acc_cmd_bits,
    input  logic [NUM_ACCEL-1:0]      acc_resp_valid,
    output logic [NUM_ACCEL-1:0]      acc_resp_ready,
    input  logic [5*NUM_ACCEL-1:0]    acc_resp_rd,
    input  logic [XLEN*NUM_ACCEL-1:0] acc_resp_data,
    output logic                      core_resp_valid,
    input  logic                      core_resp_ready,
    output logic [4:0]                core_resp_rd,
    output logic [XLEN-1:0]           core_resp_data,
    input  logic [NUM_ACCEL-1:0]      acc_busy,
    input  logic [NUM_ACCEL-1:0]      acc_interrupt,
    output logic                      core_busy,
    output logic                      core_interrupt
`ifdef ROCC_ARB_PERF_EN
    ,
    output logic [32*NUM_ACCEL-1:0]   perf_issued,
    output logic [31:0]               perf_stall
`endif
);

    // Index NUM_ACCEL in the response arbiter is the internal (bad command) source
    localparam int NS = NUM_ACCEL + 1;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    rocc_cmd_t     cmd_q_q, cmd_q_d;
    logic          cmd_q_valid_q, cmd_q_valid_d;
    logic [2:0]    cnt_q [NUM_ACCEL];
    logic [2:0]    cnt_d [NUM_ACCEL];
    logic          int_valid_q, int_valid_d;
    logic [4:0]    int_rd_q, int_rd_d;
    logic          bad_cmd_q, bad_cmd_d;

    logic [1:0]    tgt_s;
    logic          mapped_s, cnt_full_s, tgt_ready_s;
    logic          issue_ok_s, issue_hs_s, unmapped_take_s, deq_s;
    logic          cnt_any_s, int_hs_s;
    logic          gnt_valid_s;
    logic [IW-1:0] gnt_idx_s;
    logic          resp_ready_s;

    // Target decode and issue / drain conditions for the queued command
    always_comb begin
        tgt_s       = cmd_target(cmd_q_q.opcode);
        mapped_s    = 1'b0;
        cnt_full_s  = 1'b0;
        tgt_ready_s = 1'b0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            mapped_s    = mapped_s | (int'(tgt_s) == i);
            cnt_full_s  = cnt_full_s | ((int'(tgt_s) == i) && (cnt_q[i] == 3'd7));
            tgt_ready_s = tgt_ready_s | ((int'(tgt_s) == i) && acc_cmd_ready[i]);
        end
        issue_ok_s      = cmd_q_valid_q && mapped_s && !(cmd_q_q.xd && cnt_full_s);
        issue_hs_s      = issue_ok_s && tgt_ready_s;
        // an unmapped xd command needs the internal response slot free
        unmapped_take_s = cmd_q_valid_q && !mapped_s && !(cmd_q_q.xd && int_valid_q);
        deq_s           = issue_hs_s || unmapped_take_s;
        core_cmd_ready  = !cmd_q_valid_q || deq_s;
        acc_cmd_bits    = cmd_q_q;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            acc_cmd_valid[i] = issue_ok_s && (int'(tgt_s) == i);
        end
    end

    // Response path is gated by reset so nothing looks valid while reset is low
    assign resp_ready_s = core_resp_ready && reset;

    rocc_rr_arbiter #(.N(NS)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       ({int_valid_q, acc_resp_valid}),
        .ready     (resp_ready_s),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Response mux, per-accelerator ready, busy and interrupt summaries
    always_comb begin
        core_resp_valid = gnt_valid_s && reset;
        core_resp_rd    = int_rd_q;
        core_resp_data  = {XLEN{1'b1}};
        cnt_any_s       = 1'b0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            core_resp_rd      = (gnt_idx_s == IW'(i)) ? acc_resp_rd[5*i +: 5] : core_resp_rd;
            core_resp_data    = (gnt_idx_s == IW'(i)) ? acc_resp_data[XLEN*i +: XLEN] : core_resp_data;
            acc_resp_ready[i] = resp_ready_s && gnt_valid_s && (gnt_idx_s == IW'(i));
            cnt_any_s         = cnt_any_s | (cnt_q[i] != 3'd0);
        end
        int_hs_s       = resp_ready_s && gnt_valid_s && (gnt_idx_s == IW'(NUM_ACCEL));
        core_busy      = cmd_q_valid_q | (|acc_busy) | cnt_any_s | int_valid_q;
        core_interrupt = (|acc_interrupt) | bad_cmd_q;
    end

    // Next-state for the command slot, outstanding counters and internal response
    always_comb begin
        if (core_cmd_valid && core_cmd_ready) begin
            cmd_q_d       = core_cmd_bits;
            cmd_q_valid_d = 1'b1;
        end else if (deq_s) begin
            cmd_q_d       = cmd_q_q;
            cmd_q_valid_d = 1'b0;
        end else begin
            cmd_q_d       = cmd_q_q;
            cmd_q_valid_d = cmd_q_valid_q;
        end

        for (int i = 0; i < NUM_ACCEL; i++) begin
            // a response with nothing outstanding is ignored rather than wrapping the counter
            case ({issue_hs_s && cmd_q_q.xd && (int'(tgt_s) == i),
                   acc_resp_valid[i] && acc_resp_ready[i] && (cnt_q[i] != 3'd0)})
                2'b10:   cnt_d[i] = cnt_q[i] + 3'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 3'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        if (unmapped_take_s && cmd_q_q.xd) begin
            int_valid_d = 1'b1;
            int_rd_d    = cmd_q_q.rd;
        end else if (int_hs_s) begin
            int_valid_d = 1'b0;
            int_rd_d    = int_rd_q;
        end else begin
            int_valid_d = int_valid_q;
            int_rd_d    = int_rd_q;
        end

        if (unmapped_take_s && (cmd_q_q.funct == FUNCT_CLEAR_BAD)) begin
            bad_cmd_d = 1'b0;
        end else if (unmapped_take_s && cmd_q_q.xd) begin
            bad_cmd_d = 1'b1;
        end else begin
            bad_cmd_d = bad_cmd_q;
        end
    end

    // Control and datapath state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_q_q       <= '0;
            cmd_q_valid_q <= 1'b0;
            int_valid_q   <= 1'b0;
            int_rd_q      <= 5'd0;
            bad_cmd_q     <= 1'b0;
            for (int i = 0; i < NUM_ACCEL; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            cmd_q_q       <= cmd_q_d;
            cmd_q_valid_q <= cmd_q_valid_d;
            int_valid_q   <= int_valid_d;
            int_rd_q      <= int_rd_d;
            bad_cmd_q     <= bad_cmd_d;
            for (int i = 0; i < NUM_ACCEL; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef ROCC_ARB_PERF_EN
    logic [31:0] perf_issued_q [NUM_ACCEL];
    logic [31:0] perf_issued_d [NUM_ACCEL];
    logic [31:0] perf_stall_q, perf_stall_d;

    // Issue and stall counters, free-running with natural wrap
    always_comb begin
        for (int i = 0; i < NUM_ACCEL; i++) begin
            perf_issued_d[i]        = perf_issued_q[i] + ((issue_hs_s && (int'(tgt_s) == i)) ? 32'd1 : 32'd0);
            perf_issued[32*i +: 32] = perf_issued_q[i];
        end
        perf_stall_d = perf_stall_q + ((cmd_q_valid_q && !issue_hs_s) ? 32'd1 : 32'd0);
        perf_stall   = perf_stall_q;
    end

    // Performance counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= 32'd0;
            for (int i = 0; i < NUM_ACCEL; i++) begin
                perf_issued_q[i] <= 32'd0;
            end
        end else begin
            perf_stall_q <= perf_stall_d;
            for (int i = 0; i < NUM_ACCEL; i++) begin
                perf_issued_q[i] <= perf_issued_d[i];
            end
        end
    end
`endif

endmodule
